// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku board checker.
// The scheduler and its address helper both import this package.
package sudoku_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        CHECK,
        NEXT,
        DONE
    } sched_state_t;

    localparam int GRID_CELLS = 81;
    localparam int NUM_GROUPS = 27;
    localparam int GROUP_LEN  = 9;
    localparam logic [8:0] FULL_MASK = 9'h1FF;

    localparam int ROW_BASE = 0;
    localparam int COL_BASE = 9;
    localparam int BOX_BASE = 18;

endpackage

// File: rtl/sudoku_check_sched_if.sv
// Grid memory read port. The scheduler issues mem_rd/mem_addr and
// mem_rdata returns one cycle later.
interface sudoku_check_sched_if #(
    parameter int ADDR_W = 17
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_rdata;

    modport master (output mem_rd, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/sudoku_cell_addr.sv
// Maps (constraint group, position k) to a cell offset inside one board.
// Divide/modulo by 3 come from small constant tables instead of dividers.
module sudoku_cell_addr
    import sudoku_pkg::*;
(
    input  logic [4:0] group,
    input  logic [3:0] k,
    output logic [6:0] offset
);

    logic [1:0] div3_lut [16];
    logic [1:0] mod3_lut [16];
    logic [3:0] idx;
    logic [6:0] box_row;
    logic [6:0] box_col;

    // Entries above 8 never occur for legal inputs; they just keep the table full.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lut
            assign div3_lut[gi] = 2'((gi % 9) / 3);
            assign mod3_lut[gi] = 2'(gi % 3);
        end
    endgenerate

    always_comb begin
        idx     = 4'd0;
        box_row = 7'd0;
        box_col = 7'd0;
        offset  = 7'd0;
        if (group < 5'(COL_BASE)) begin
            idx    = 4'(group - 5'(ROW_BASE));
            offset = 7'(idx) * 7'd9 + 7'(k);
        end else if (group < 5'(BOX_BASE)) begin
            idx    = 4'(group - 5'(COL_BASE));
            offset = 7'(k) * 7'd9 + 7'(idx);
        end else begin
            idx     = 4'(group - 5'(BOX_BASE));
            box_row = 7'(div3_lut[idx]) * 7'd3 + 7'(div3_lut[k]);
            box_col = 7'(mod3_lut[idx]) * 7'd3 + 7'(mod3_lut[k]);
            offset  = box_row * 7'd9 + box_col;
        end
    end

endmodule

// File: rtl/sudoku_check_sched.sv
// Walks NUM_BOARDS packed boards, runs all 27 groups of each through one
// digit-set mask, and tallies correct/wrong boards plus busy cycles.
module sudoku_check_sched
    import sudoku_pkg::*;
#(
    parameter int NUM_BOARDS = 1000,
    parameter int ADDR_W     = 17,
    parameter int CNT_W      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    sudoku_check_sched_if.master      mem,
    output logic                      busy,
    output logic                      done,
    output logic                      board_valid,
    output logic                      board_ok,
    output logic [CNT_W-1:0]          num_correct,
    output logic [CNT_W-1:0]          num_wrong,
    output logic [31:0]               cycles
);

    localparam int BOARD_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
    localparam logic [BOARD_W-1:0] LAST_BOARD = BOARD_W'(NUM_BOARDS - 1);

    sched_state_t      state_reg, state_next;
    logic [BOARD_W-1:0] board_reg, board_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [4:0]        group_reg, group_next;
    logic [3:0]        k_reg, k_next;
    logic [8:0]        mask_reg, mask_next;
    logic [8:0]        hit;
    logic              fail_reg, fail_next;
    logic              pend_reg;
    logic              rd_reg, rd_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  correct_reg, correct_next;
    logic [CNT_W-1:0]  wrong_reg, wrong_next;
    logic [31:0]       cycles_reg, cycles_next;
    logic [6:0]        offset;

    // Address is computed for the step about to be issued so mem_rd/mem_addr can be registered.
    sudoku_cell_addr u_cell_addr (
        .group  (group_next),
        .k      (k_next),
        .offset (offset)
    );

    genvar gi;
    generate
        for (gi = 0; gi < GROUP_LEN; gi++) begin : g_hit
            assign hit[gi] = pend_reg && (mem.mem_rdata == 4'(gi + 1));
        end
    endgenerate

    assign busy = (state_reg == FETCH) || (state_reg == DRAIN) ||
                  (state_reg == CHECK) || (state_reg == NEXT);
    assign done = (state_reg == DONE);

    always_comb begin
        state_next   = state_reg;
        board_next   = board_reg;
        base_next    = base_reg;
        group_next   = group_reg;
        k_next       = k_reg;
        mask_next    = mask_reg | hit;
        fail_next    = fail_reg;
        correct_next = correct_reg;
        wrong_next   = wrong_reg;
        cycles_next  = (busy && cycles_reg != '1) ? cycles_reg + 32'd1 : cycles_reg;
        board_valid  = 1'b0;
        board_ok     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = FETCH;
                    board_next   = '0;
                    base_next    = '0;
                    group_next   = '0;
                    k_next       = '0;
                    mask_next    = '0;
                    fail_next    = 1'b0;
                    correct_next = '0;
                    wrong_next   = '0;
                    cycles_next  = '0;
                end
            end
            FETCH: begin
                k_next = k_reg + 4'd1;
                if (k_reg == 4'(GROUP_LEN - 1)) state_next = DRAIN;
            end
            DRAIN: state_next = CHECK;
            CHECK: begin
                if (mask_reg != FULL_MASK) fail_next = 1'b1;
                mask_next = '0;
                k_next    = '0;
                if (group_reg < 5'(NUM_GROUPS - 1)) begin
                    group_next = group_reg + 5'd1;
                    state_next = FETCH;
                end else begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                board_valid = 1'b1;
                board_ok    = ~fail_reg;
                if (fail_reg) begin
                    if (wrong_reg != '1) wrong_next = wrong_reg + 1'b1;
                end else begin
                    if (correct_reg != '1) correct_next = correct_reg + 1'b1;
                end
                fail_next  = 1'b0;
                group_next = '0;
                if (board_reg != LAST_BOARD) begin
                    board_next = board_reg + 1'b1;
                    base_next  = base_reg + ADDR_W'(GRID_CELLS);
                    state_next = FETCH;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        rd_next   = (state_next == FETCH);
        addr_next = rd_next ? base_next + ADDR_W'(offset) : addr_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            board_reg   <= '0;
            base_reg    <= '0;
            group_reg   <= '0;
            k_reg       <= '0;
            mask_reg    <= '0;
            fail_reg    <= 1'b0;
            pend_reg    <= 1'b0;
            rd_reg      <= 1'b0;
            addr_reg    <= '0;
            correct_reg <= '0;
            wrong_reg   <= '0;
            cycles_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            board_reg   <= board_next;
            base_reg    <= base_next;
            group_reg   <= group_next;
            k_reg       <= k_next;
            mask_reg    <= mask_next;
            fail_reg    <= fail_next;
            pend_reg    <= rd_reg;
            rd_reg      <= rd_next;
            addr_reg    <= addr_next;
            correct_reg <= correct_next;
            wrong_reg   <= wrong_next;
            cycles_reg  <= cycles_next;
        end
    end

    assign mem.mem_rd   = rd_reg;
    assign mem.mem_addr = addr_reg;
    assign num_correct  = correct_reg;
    assign num_wrong    = wrong_reg;
    assign cycles       = cycles_reg;

endmodule

// File: tb/tb_sudoku_check_sched.sv
// Scoreboard bench: a 3-board checker driven with random boards and a
// 5-board, 2-bit-counter checker for saturation.
module tb_sudoku_check_sched;
    import sudoku_pkg::*;

    localparam int NB_A = 3;
    localparam int NB_B = 5;
    localparam int CW_A = 10;
    localparam int CW_B = 2;
    localparam int AW   = 17;
    localparam int BOARD_CYC = 298;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    sudoku_check_sched_if #(.ADDR_W(AW)) mif_a ();
    sudoku_check_sched_if #(.ADDR_W(AW)) mif_b ();

    logic            busy_a, done_a, board_valid_a, board_ok_a;
    logic [CW_A-1:0] num_correct_a, num_wrong_a;
    logic [31:0]     cycles_a;
    logic            busy_b, done_b, board_valid_b, board_ok_b;
    logic [CW_B-1:0] num_correct_b, num_wrong_b;
    logic [31:0]     cycles_b;

    sudoku_check_sched #(.NUM_BOARDS(NB_A), .ADDR_W(AW), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mem(mif_a.master),
        .busy(busy_a), .done(done_a), .board_valid(board_valid_a), .board_ok(board_ok_a),
        .num_correct(num_correct_a), .num_wrong(num_wrong_a), .cycles(cycles_a)
    );

    sudoku_check_sched #(.NUM_BOARDS(NB_B), .ADDR_W(AW), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem(mif_b.master),
        .busy(busy_b), .done(done_b), .board_valid(board_valid_b), .board_ok(board_ok_b),
        .num_correct(num_correct_b), .num_wrong(num_wrong_b), .cycles(cycles_b)
    );

    logic [3:0] mem_a [NB_A*81];
    logic [3:0] mem_b [NB_B*81];

    always @(posedge clk) begin
        if (mif_a.mem_rd)
            mif_a.mem_rdata <= (int'(mif_a.mem_addr) < NB_A*81) ? mem_a[int'(mif_a.mem_addr)] : 4'h0;
        if (mif_b.mem_rd)
            mif_b.mem_rdata <= (int'(mif_b.mem_addr) < NB_B*81) ? mem_b[int'(mif_b.mem_addr)] : 4'h0;
    end

    typedef struct {
        bit ok;
        int pos;
    } verdict_t;

    verdict_t vq[$];
    int       aq[$];
    int       vectors = 0;
    int       miscompares = 0;
    int       busy_seen = 0;
    int       board_seen = 0;
    int       pulses_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cell index of position k in group g, from row/column/box rules.
    function automatic int cell_of(input int g, input int k);
        int b;
        if (g < 9) return g * 9 + k;
        if (g < 18) return k * 9 + (g - 9);
        b = g - 18;
        return ((b / 3) * 3 + k / 3) * 9 + (b % 3) * 3 + k % 3;
    endfunction

    // Board is correct iff every digit appears exactly once in every row, column and box.
    function automatic bit ref_ok(input int b);
        int cnt [3][9][9];
        int v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 9; j++)
                for (int d = 0; d < 9; d++) cnt[i][j][d] = 0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                v = int'(mem_a[b*81 + r*9 + c]);
                if (v >= 1 && v <= 9) begin
                    cnt[0][r][v-1]++;
                    cnt[1][c][v-1]++;
                    cnt[2][(r/3)*3 + c/3][v-1]++;
                end
            end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 9; j++)
                for (int d = 0; d < 9; d++)
                    if (cnt[i][j][d] != 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic make_valid(input int b, input bit to_b);
        int perm[9];
        int j, t;
        for (int i = 0; i < 9; i++) perm[i] = i + 1;
        for (int i = 8; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                if (to_b) mem_b[b*81 + r*9 + c] = 4'(perm[(r*3 + r/3 + c) % 9]);
                else      mem_a[b*81 + r*9 + c] = 4'(perm[(r*3 + r/3 + c) % 9]);
            end
    endtask

    task automatic mutate(input int b, input int kind);
        logic [3:0] t;
        int i, j, r;
        case (kind)
            1: begin t = mem_a[b*81]; mem_a[b*81] = mem_a[b*81+1]; mem_a[b*81+1] = t; end
            2: mem_a[b*81 + 40] = 4'd0;
            3: mem_a[b*81 + 40] = 4'd12;
            4: mem_a[b*81 + $urandom_range(80, 0)] = 4'($urandom_range(15, 0));
            5: begin
                r = $urandom_range(8, 0);
                i = r*9 + $urandom_range(8, 0);
                j = r*9 + $urandom_range(8, 0);
                t = mem_a[b*81+i]; mem_a[b*81+i] = mem_a[b*81+j]; mem_a[b*81+j] = t;
            end
            default: ;
        endcase
    endtask

    task automatic load_expectations(output int exp_c, output int exp_w);
        verdict_t v;
        exp_c = 0;
        exp_w = 0;
        aq.delete();
        vq.delete();
        for (int b = 0; b < NB_A; b++) begin
            v.ok  = ref_ok(b);
            v.pos = BOARD_CYC * (b + 1);
            vq.push_back(v);
            if (v.ok) exp_c++; else exp_w++;
            for (int g = 0; g < 27; g++)
                for (int k = 0; k < 9; k++) aq.push_back(b*81 + cell_of(g, k));
        end
        busy_seen  = 0;
        board_seen = 0;
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic run_a();
        int exp_c, exp_w, n;
        load_expectations(exp_c, exp_w);
        pulse_start_a();
        n = 0;
        while (!done_a && n < NB_A*BOARD_CYC + 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_a", done_a, 1);
        check("busy_a_final", busy_a, 0);
        check("num_correct_a", num_correct_a, exp_c);
        check("num_wrong_a", num_wrong_a, exp_w);
        check("cycles_a", cycles_a, NB_A*BOARD_CYC);
        check("verdicts_left_a", vq.size(), 0);
        check("addrs_left_a", aq.size(), 0);
        aq.delete();
        vq.delete();
    endtask

    // Monitor: compares every issued address and every verdict against the queues.
    always @(negedge clk) begin
        verdict_t e;
        if (!rst) begin
            if (busy_a) busy_seen++;
            if (mif_a.mem_rd) begin
                if (aq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL mem_addr_extra: got read of %0d, expected no read", mif_a.mem_addr);
                end else begin
                    check("mem_addr", mif_a.mem_addr, aq.pop_front());
                end
            end
            if (board_valid_a) begin
                if (vq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL verdict_extra: got board_ok=%0b, expected no verdict", board_ok_a);
                end else begin
                    e = vq.pop_front();
                    $display("board %0d: board_ok=%0b expected=%0b at busy cycle %0d expected %0d",
                             board_seen, board_ok_a, e.ok, busy_seen, e.pos);
                    check("board_ok", board_ok_a, e.ok);
                    check("verdict_cycle", busy_seen, e.pos);
                    board_seen++;
                end
            end
            if (board_valid_b) begin
                pulses_b++;
                check("board_ok_b", board_ok_b, 1);
            end
        end
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_mem_rd", mif_a.mem_rd, 0);
        check("rst_mem_addr", mif_a.mem_addr, 0);
        check("rst_num_correct", num_correct_a, 0);
        check("rst_num_wrong", num_wrong_a, 0);
        check("rst_cycles", cycles_a, 0);
        check("rst_board_valid", board_valid_a, 0);
        rst = 1'b0;

        for (int b = 0; b < NB_B; b++) make_valid(b, 1'b1);

        // Directed: valid / two cells swapped / valid.
        for (int b = 0; b < NB_A; b++) make_valid(b, 1'b0);
        mutate(1, 1);
        run_a();

        // Directed: centre cell blanked, centre cell out of range, valid.
        for (int b = 0; b < NB_A; b++) make_valid(b, 1'b0);
        mutate(0, 2);
        mutate(1, 3);
        run_a();

        for (int run = 0; run < 3; run++) begin
            for (int b = 0; b < NB_A; b++) begin
                make_valid(b, 1'b0);
                mutate(b, $urandom_range(5, 0));
            end
            run_a();
        end

        // Reset in the middle of fetching board 1, then a clean rerun.
        for (int b = 0; b < NB_A; b++) begin
            make_valid(b, 1'b0);
            mutate(b, $urandom_range(5, 0));
        end
        load_expectations(n, n);
        pulse_start_a();
        n = 0;
        while (busy_seen < BOARD_CYC + 30 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_board1", busy_seen >= BOARD_CYC + 30, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_mem_rd", mif_a.mem_rd, 0);
        check("mid_rst_mem_addr", mif_a.mem_addr, 0);
        check("mid_rst_num_correct", num_correct_a, 0);
        check("mid_rst_num_wrong", num_wrong_a, 0);
        check("mid_rst_cycles", cycles_a, 0);
        aq.delete();
        vq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_a();

        // Saturation: five correct boards into a 2-bit counter.
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (!done_b && n < NB_B*BOARD_CYC + 50) begin
            @(posedge clk); #1;
            n++;
        end
        $display("saturation run: num_correct=%0d num_wrong=%0d cycles=%0d pulses=%0d",
                 num_correct_b, num_wrong_b, cycles_b, pulses_b);
        check("done_b", done_b, 1);
        check("num_correct_b_sat", num_correct_b, 3);
        check("num_wrong_b", num_wrong_b, 0);
        check("cycles_b", cycles_b, NB_B*BOARD_CYC);
        check("pulses_b", pulses_b, NB_B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
